// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and occupancy count.
//
// Ports:
//   clk          - clock; all state changes on the rising edge
//   rst_n        - synchronous reset, active HIGH (1 clears state at the next edge)
//   wr_en        - write request; wr_data is sampled when the write is accepted
//   wr_data      - write data
//   rd_en        - read request; rd_data is updated one cycle after acceptance
//   rd_data      - registered read data; holds when no read is accepted
//   full/empty   - count == DEPTH / count == 0
//   almost_full  - count >= DEPTH-2
//   almost_empty - count <= 2
//   overflow     - one-cycle pulse after a rejected write
//   underflow    - one-cycle pulse after a rejected read
//   count        - occupancy, 0..DEPTH
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_BITS  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow,
   output logic [ADDR_BITS:0]    count
);

   localparam logic [ADDR_BITS:0]   CNT_DEPTH = (ADDR_BITS+1)'(DEPTH);
   localparam logic [ADDR_BITS:0]   CNT_AF    = (ADDR_BITS+1)'(DEPTH-2);
   localparam logic [ADDR_BITS:0]   CNT_AE    = (ADDR_BITS+1)'(2);
   localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS+1)'(1);
   localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]    count_q, count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;

   // Flags decode straight from the registered count.
   assign full         = (count_q == CNT_DEPTH);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CNT_AF);
   assign almost_empty = (count_q <= CNT_AE);

   // A write into a full FIFO is still accepted when a read frees a slot in
   // the same cycle. The read side never borrows from a same-cycle write.
   assign wr_acc = wr_en && (!full || rd_en);
   assign rd_acc = rd_en && !empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rd_data_d   = rd_data_q;
      overflow_d  = wr_en && full && !rd_en;
      underflow_d = rd_en && empty;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
         rd_data_d = mem[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rd_data_q   <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_data_q   <= rd_data_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; a write is simply dropped on a reset edge.
   always_ff @(posedge clk) begin
      if (!rst_n && wr_acc) mem[wr_ptr_q] <= wr_data;
   end

   assign rd_data   = rd_data_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign count     = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with a queue scoreboard and an occupancy model.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0] count;

   int checks   = 0;
   int failures = 0;

   logic [7:0] sb_q [$];
   int         m_cnt;
   logic [7:0] last_rd;

   sync_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input logic exp_ovf, input logic exp_udf);
      chk("count",        32'(count),        32'(m_cnt));
      chk("empty",        32'(empty),        32'(m_cnt == 0));
      chk("full",         32'(full),         32'(m_cnt == 16));
      chk("almost_full",  32'(almost_full),  32'(m_cnt >= 14));
      chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 2));
      chk("overflow",     32'(overflow),     32'(exp_ovf));
      chk("underflow",    32'(underflow),    32'(exp_udf));
   endtask

   // One clock of stimulus; the model decides acceptance from its own count.
   task automatic step(input logic w, input logic [7:0] d, input logic r);
      logic wa, ra, e_ovf, e_udf;
      logic [7:0] e;
      rst_n = 1'b0; wr_en = w; wr_data = d; rd_en = r;
      e_ovf = w && (m_cnt == 16) && !r;
      e_udf = r && (m_cnt == 0);
      wa    = w && ((m_cnt != 16) || r);
      ra    = r && (m_cnt != 0);
      @(posedge clk); #1;
      if (ra) begin
         e = sb_q.pop_front();
         chk("rd_data", 32'(rd_data), 32'(e));
         last_rd = e;
      end else begin
         chk("rd_hold", 32'(rd_data), 32'(last_rd));
      end
      if (wa) sb_q.push_back(d);
      if (wa && !ra) m_cnt++;
      if (ra && !wa) m_cnt--;
      chk_flags(e_ovf, e_udf);
   endtask

   task automatic do_reset(input logic w, input logic [7:0] d, input logic r);
      rst_n = 1'b1; wr_en = w; wr_data = d; rd_en = r;
      @(posedge clk); #1;
      sb_q.delete();
      m_cnt   = 0;
      last_rd = 8'h00;
      chk("rst_rd_data", 32'(rd_data), 32'h0);
      chk_flags(1'b0, 1'b0);
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      m_cnt = 0; last_rd = 8'h00;
      rst_n = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
      #1;
      // Reset then idle
      do_reset(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);

      // Fill with random data, then drain in order
      for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

      // Overflow while full: 0xAA must not enter the scoreboard or the FIFO
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i * 7 + 3), 1'b0);
      step(1'b1, 8'hAA, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

      // Underflow while empty: rd_data must hold the last word read
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Empty with simultaneous read/write, then occupancy thresholds
      step(1'b1, 8'h55, 1'b1);
      for (int i = 0; i < 13; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
      for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 14; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
      step(1'b1, 8'hC3, 1'b1);
      step(1'b1, 8'hC4, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Mid-operation reset with a pending 0xFF write
      step(1'b1, 8'h12, 1'b1);
      do_reset(1'b1, 8'hFF, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h11, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each data word, in bits.
REQ-002 Parameter DEPTH, default 16: number of storage entries; a power of two, minimum 4.
REQ-003 Parameter ADDR_BITS, default $clog2(DEPTH): width of the read and write pointers.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-high (rst_n=1 resets at the next rising edge).
REQ-006 wr_en  input  1  write request.
REQ-007 wr_data  input  DATA_WIDTH  write data, sampled on an accepted write.
REQ-008 rd_en  input  1  read request.
REQ-009 rd_data  output  DATA_WIDTH  registered read data.
REQ-010 full  output  1  count == DEPTH.
REQ-011 empty  output  1  count == 0.
REQ-012 almost_full  output  1  count >= DEPTH-2.
REQ-013 almost_empty  output  1  count <= 2.
REQ-014 overflow  output  1  registered one-cycle pulse for a rejected write.
REQ-015 underflow  output  1  registered one-cycle pulse for a rejected read.
REQ-016 count  output  ADDR_BITS+1  current occupancy, 0..DEPTH.

Function
REQ-017 Storage SHALL be a DEPTH x DATA_WIDTH array, with write and read pointers of ADDR_BITS bits that wrap from DEPTH-1 to 0.
REQ-018 Write acceptance SHALL be wr_en && (!full || rd_en).
- On an accepted write: mem[wr_ptr] <= wr_data and wr_ptr increments.
REQ-019 Read acceptance SHALL be rd_en && !empty.
- On an accepted read: rd_data <= mem[rd_ptr] and rd_ptr increments.
- Read latency is 1 cycle; rd_data holds its value when no read is accepted.
REQ-020 count SHALL be registered and update as follows:
- +1 on write only; -1 on read only.
- Unchanged on both or neither.
REQ-021 When the FIFO is full and wr_en && rd_en: both operations SHALL be accepted and count SHALL stay at DEPTH.
REQ-022 When the FIFO is empty and wr_en && rd_en: the read SHALL be rejected, the write accepted, count becomes 1, and underflow pulses.
REQ-023 full, empty, almost_full and almost_empty SHALL be combinational decodes of the registered count.
REQ-024 overflow SHALL be 1 for exactly the cycle after an edge where wr_en && full && !rd_en, and 0 otherwise.
REQ-025 underflow SHALL be 1 for exactly the cycle after an edge where rd_en && empty, and 0 otherwise.
REQ-026 A rejected write or read SHALL leave the memory, pointers, count and rd_data unchanged.
REQ-027 Data SHALL leave the FIFO in write order, including across pointer wrap-around.

Reset
REQ-028 Reset SHALL take priority over simultaneous wr_en and rd_en.
REQ-029 At any rising edge with rst_n=1, the block SHALL set:
- wr_ptr, rd_ptr and count to 0.
- rd_data to 0.
- overflow and underflow to 0.
REQ-030 Consequently, after reset the flags SHALL be:
- empty=1 and almost_empty=1.
- full=0 and almost_full=0.
REQ-031 Memory contents need not be cleared by reset.

Verification
REQ-032 Reset, then idle -> empty=1, count=0, full=0, overflow=0, underflow=0.
REQ-033 16 consecutive writes of random data, then read all 16 -> after the writes: full=1, count=16, almost_full=1. After the reads: rd_data matches write order, empty=1, count=0.
REQ-034 While full, write 0xAA with rd_en=0 -> overflow=1 for one cycle, count stays 16, and 0xAA is never read out.
REQ-035 While empty, assert rd_en for one cycle -> underflow=1 for one cycle, count stays 0, rd_data unchanged.
REQ-036 Occupancy and simultaneous-access checks:
- From empty, write 0x55 with rd_en=1 -> count=1.
- 13 further writes (count 14) -> almost_full=1.
- Then 12 reads (count 2) -> almost_empty=1.
- At full, simultaneous read and write -> count stays 16 and no overflow.
REQ-037 Mid-operation, wr_en=1 with wr_data=0xFF, then rst_n=1 for one edge -> empty=1, count=0; the 0xFF write is discarded.
